stream_rr_arbiter: RTL and testbench

//  - Parametrised N-to-1 valid/ready stream arbiter with round-robin fairness and a bounded burst length.
//  - Funnels many per-level serializer streams onto the single Avalon bridge write stream.
//  - Registered output stage: out_valid/out_data/out_ch are flops, with full backpressure support.
//  - Channel-select logic is generic for any NUM_CH; no per-channel hand-coded cases.

---
 rtl/stream_rr_arbiter.sv | 186 ++++++++++++++++++
 tb/tb_stream_rr_arbiter.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/stream_rr_arbiter.sv
// ============================================================================
// Module      : stream_rr_arbiter
// Description : N-to-1 round-robin valid/ready stream arbiter with bounded
//               bursts and a registered output stage. Optional packet-aligned
//               release via `STREAM_ARB_LAST_EN (adds in_last/out_last).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module stream_rr_arbiter #(
    parameter int NUM_CH     = 7,
    parameter int DATA_WIDTH = 128,
    parameter int MAX_BURST  = 9,
    localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    localparam int CNT_W     = $clog2(MAX_BURST + 1)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_CH-1:0]            in_valid,
    input  logic [NUM_CH*DATA_WIDTH-1:0] in_data,
    output logic [NUM_CH-1:0]            in_ready,
`ifdef STREAM_ARB_LAST_EN
    input  logic [NUM_CH-1:0]            in_last,
    output logic                         out_last,
`endif
    output logic                         out_valid,
    output logic [DATA_WIDTH-1:0]        out_data,
    output logic [CH_W-1:0]              out_ch,
    input  logic                         out_ready
);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    state_t                 state_q, state_d;
    logic [CH_W-1:0]        rr_ptr_q, rr_ptr_d;
    logic [CH_W-1:0]        gnt_q, gnt_d;
    logic [CNT_W-1:0]       beat_cnt_q, beat_cnt_d;

    logic                   out_valid_q;
    logic [DATA_WIDTH-1:0]  out_data_q;
    logic [CH_W-1:0]        out_ch_q;
    logic                   out_last_q;

    logic [2*NUM_CH-1:0]    w_req_dbl;
    logic [NUM_CH-1:0]      w_req_rot;
    logic [CH_W-1:0]        w_pick_off;
    logic [CH_W:0]          w_pick_sum;
    logic [CH_W-1:0]        w_pick_idx;
    logic                   w_pick_any;

    logic                   w_gnt_valid;
    logic                   w_can_load;
    logic                   w_accept;
    logic                   w_burst_end;
    logic                   w_last_hit;
    logic                   w_release;
    logic [CH_W-1:0]        w_ptr_next;
    logic [DATA_WIDTH-1:0]  w_sel_data;
    logic                   w_sel_last;

    // Rotate requests so that bit 0 corresponds to rr_ptr; the lowest set
    // bit of the rotated vector is then the round-robin winner's offset.
    assign w_req_dbl  = {in_valid, in_valid};
    assign w_req_rot  = w_req_dbl[rr_ptr_q +: NUM_CH];
    assign w_pick_any = |in_valid;

    always_comb begin
        w_pick_off = '0;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            if (w_req_rot[k]) begin
                w_pick_off = CH_W'(k);
            end
        end
    end

    assign w_pick_sum = {1'b0, rr_ptr_q} + {1'b0, w_pick_off};
    assign w_pick_idx = (w_pick_sum >= (CH_W+1)'(NUM_CH))
                      ? CH_W'(w_pick_sum - (CH_W+1)'(NUM_CH))
                      : w_pick_sum[CH_W-1:0];

    assign w_gnt_valid = in_valid[gnt_q];
    assign w_can_load  = ~out_valid_q | out_ready;
    assign w_accept    = (state_q == ST_GRANT) & w_gnt_valid & w_can_load;
    assign w_burst_end = w_accept & (beat_cnt_q == CNT_W'(MAX_BURST - 1));
    assign w_sel_data  = in_data[gnt_q*DATA_WIDTH +: DATA_WIDTH];

`ifdef STREAM_ARB_LAST_EN
    assign w_sel_last  = in_last[gnt_q];
    assign w_last_hit  = w_accept & w_sel_last;
`else
    assign w_sel_last  = 1'b0;
    assign w_last_hit  = 1'b0;
`endif

    // A dropped request releases the grant even while backpressured.
    assign w_release  = ~w_gnt_valid | w_burst_end | w_last_hit;
    assign w_ptr_next = (gnt_q == CH_W'(NUM_CH - 1)) ? '0 : gnt_q + 1'b1;

    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        gnt_d      = gnt_q;
        beat_cnt_d = beat_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (w_pick_any) begin
                    gnt_d      = w_pick_idx;
                    beat_cnt_d = '0;
                    state_d    = ST_GRANT;
                end
            end
            ST_GRANT: begin
                if (w_accept) begin
                    beat_cnt_d = beat_cnt_q + 1'b1;
                end
                if (w_release) begin
                    state_d  = ST_IDLE;
                    rr_ptr_d = w_ptr_next;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        in_ready        = '0;
        in_ready[gnt_q] = w_accept;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            rr_ptr_q   <= '0;
            gnt_q      <= '0;
            beat_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            gnt_q      <= gnt_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

    // Output stage drains independently of the arbitration state; a new
    // accept on the same cycle as an unload simply overwrites the slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ch_q    <= '0;
            out_last_q  <= 1'b0;
        end else if (w_accept) begin
            out_valid_q <= 1'b1;
            out_data_q  <= w_sel_data;
            out_ch_q    <= gnt_q;
            out_last_q  <= w_sel_last;
        end else if (out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_ch    = out_ch_q;

`ifdef STREAM_ARB_LAST_EN
    assign out_last  = out_last_q;
`else
    logic w_unused;
    assign w_unused  = out_last_q;
`endif

    a_ready_onehot: assert property (@(posedge clk) disable iff (!rst_n)
        $onehot0(in_ready));

    a_out_hold: assert property (@(posedge clk) disable iff (!rst_n)
        (out_valid && !out_ready) |=> (out_valid && $stable(out_data) && $stable(out_ch)));

endmodule

`default_nettype wire

// File: tb/tb_stream_rr_arbiter.sv
// ============================================================================
// Module      : tb_stream_rr_arbiter
// Description : Scoreboard bench for stream_rr_arbiter with a behavioural
//               round-robin reference model and randomized traffic.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_stream_rr_arbiter;

    localparam int NUM_CH = 7;
    localparam int DW     = 128;
    localparam int MB     = 9;
    localparam int CH_W   = 3;

    logic                   clk;
    logic                   rst_n;
    logic [NUM_CH-1:0]      in_valid;
    logic [NUM_CH*DW-1:0]   in_data;
    logic [NUM_CH-1:0]      in_ready;
    logic                   out_valid;
    logic [DW-1:0]          out_data;
    logic [CH_W-1:0]        out_ch;
    logic                   out_ready;
`ifdef STREAM_ARB_LAST_EN
    logic [NUM_CH-1:0]      in_last;
    logic                   out_last;
`endif

    stream_rr_arbiter #(
        .NUM_CH     (NUM_CH),
        .DATA_WIDTH (DW),
        .MAX_BURST  (MB)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
`ifdef STREAM_ARB_LAST_EN
        .in_last    (in_last),
        .out_last   (out_last),
`endif
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_ch     (out_ch),
        .out_ready  (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] d;
        int            ch;
        logic          l;
    } exp_t;

    exp_t  expq[$];
    int    dut_chs[$];
    int    checks   = 0;
    int    failures = 0;

    // Reference model: grant owner (-1 = arbitrating), round-robin start,
    // beats taken in the current grant, and whether the output slot is full.
    int    owner  = -1;
    int    rr     = 0;
    int    burst  = 0;
    bit    mvalid = 1'b0;

    logic [NUM_CH-1:0] rv;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        owner  = -1;
        rr     = 0;
        burst  = 0;
        mvalid = 1'b0;
        expq.delete();
        dut_chs.delete();
    endtask

    task automatic model_step();
        logic [NUM_CH-1:0] er;
        bit                acc;
        bit                rel;
        exp_t              e;
        er  = '0;
        acc = 1'b0;
        chk("out_valid", DW'(out_valid), DW'(mvalid));
        if (owner < 0) begin
            for (int k = 0; k < NUM_CH; k++) begin
                if (in_valid[(rr + k) % NUM_CH]) begin
                    owner = (rr + k) % NUM_CH;
                    break;
                end
            end
            burst = 0;
        end else begin
            acc = in_valid[owner] && (!mvalid || out_ready);
            if (acc) begin
                er[owner] = 1'b1;
                e.d  = in_data[owner*DW +: DW];
                e.ch = owner;
`ifdef STREAM_ARB_LAST_EN
                e.l  = in_last[owner];
`else
                e.l  = 1'b0;
`endif
                expq.push_back(e);
                burst++;
            end
            rel = !in_valid[owner] || (acc && burst == MB);
`ifdef STREAM_ARB_LAST_EN
            if (acc && in_last[owner]) rel = 1'b1;
`endif
            if (rel) begin
                rr    = (owner + 1) % NUM_CH;
                owner = -1;
            end
        end
        chk("in_ready", DW'(in_ready), DW'(er));
        if (acc)                     mvalid = 1'b1;
        else if (mvalid && out_ready) mvalid = 1'b0;
    endtask

    task automatic drive(input logic [NUM_CH-1:0] v, input logic ordy);
        @(negedge clk);
        in_valid  = v;
        out_ready = ordy;
        for (int i = 0; i < NUM_CH; i++) begin
            in_data[i*DW +: DW] = {$urandom(), $urandom(), $urandom(), $urandom()};
        end
`ifdef STREAM_ARB_LAST_EN
        for (int i = 0; i < NUM_CH; i++) begin
            in_last[i] = ($urandom_range(0, 5) == 0);
        end
`endif
        #1;
        model_step();
    endtask

    task automatic check_reset_outputs();
        chk("rst_out_valid", DW'(out_valid), '0);
        chk("rst_out_data",  out_data,       '0);
        chk("rst_out_ch",    DW'(out_ch),    '0);
        chk("rst_in_ready",  DW'(in_ready),  '0);
`ifdef STREAM_ARB_LAST_EN
        chk("rst_out_last",  DW'(out_last),  '0);
`endif
    endtask

    task automatic do_reset();
        @(negedge clk);
        in_valid  = '1;
        out_ready = 1'b1;
        #3;
        rst_n = 1'b0;
        #1;
        check_reset_outputs();
        model_reset();
        repeat (2) @(negedge clk);
        #1;
        check_reset_outputs();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Monitor: pops the scoreboard on every output handshake.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (rst_n && out_valid && out_ready) begin
                if (expq.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_beat: got ch %0d data %0h expected none", out_ch, out_data);
                end else begin
                    e = expq.pop_front();
                    chk("out_data", out_data,     e.d);
                    chk("out_ch",   DW'(out_ch),  DW'(e.ch));
`ifdef STREAM_ARB_LAST_EN
                    chk("out_last", DW'(out_last), DW'(e.l));
`endif
                end
                dut_chs.push_back(int'(out_ch));
            end
        end
    end

    initial begin
        rst_n     = 1'b0;
        in_valid  = '1;
        in_data   = '0;
        out_ready = 1'b0;
`ifdef STREAM_ARB_LAST_EN
        in_last   = '0;
`endif
        @(negedge clk);
        #1;
        check_reset_outputs();
        repeat (2) @(negedge clk);
        in_valid = '0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Randomized traffic with request drops and backpressure.
        rv = '0;
        repeat (600) begin
            for (int i = 0; i < NUM_CH; i++) begin
                if ($urandom_range(0, 9) < 2) rv[i] = ~rv[i];
            end
            drive(rv, ($urandom_range(0, 9) < 7));
        end

        // Mid-run reset, then all channels requesting with no backpressure.
        do_reset();
        repeat (75) drive('1, 1'b1);
        if (dut_chs.size() < 64) begin
            checks++;
            failures++;
            $display("FAIL rr_beats: got %0d beats expected at least 64", dut_chs.size());
        end else begin
            for (int i = 0; i < 64; i++) begin
                chk("rr_order", DW'(dut_chs[i]), DW'((i / MB) % NUM_CH));
            end
        end

        // Lone requester on ch3.
        repeat (3) drive('0, 1'b1);
        dut_chs.delete();
        repeat (25) drive(NUM_CH'(8), 1'b1);
        repeat (3) drive('0, 1'b1);
        chk("lone_beats", DW'(dut_chs.size()), DW'(22));
        foreach (dut_chs[i]) chk("lone_ch", DW'(dut_chs[i]), DW'(3));

        // Backpressure stall mid-burst.
        repeat (4) drive('1, 1'b1);
        repeat (5) drive('1, 1'b0);
        repeat (6) drive('1, 1'b1);
        repeat (5) drive('0, 1'b1);
        chk("drain_empty", DW'(expq.size()), '0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
